// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator with a two-entry (output + skid) valid/ready pipeline stage.
// Optional macro IMM_GEN_ILLEGAL_EN adds out_illegal_o, an unknown-opcode flag carried with each entry.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_insr_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [2:0]       out_fmt_o,
  output logic [TAG_W-1:0] out_tag_o
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_illegal_o
`endif
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

`ifdef IMM_GEN_ILLEGAL_EN
  localparam int DW = XLEN + 3 + TAG_W + 1;
`else
  localparam int DW = XLEN + 3 + TAG_W;
`endif

  // First-match classification on opcode bits [6:2]
  function automatic logic [2:0] fmt_of(input logic [4:0] op);
    logic [2:0] f;
    if (op[2:0] == 3'b101) begin
      f = FMT_U;
    end else if (op[1:0] == 2'b11) begin
      f = FMT_J;
    end else if ((op[2:0] == 3'b001) || ({op[4:3], op[1:0]} == 4'b0000)) begin
      f = FMT_I;
    end else if (op == 5'b01000) begin
      f = FMT_S;
    end else if (op == 5'b11000) begin
      f = FMT_B;
    end else begin
      f = FMT_R;
    end
    return f;
  endfunction

  function automatic logic [XLEN-1:0] imm_of(input logic [31:7] w, input logic [2:0] fmt);
    logic [31:0] v;
    case (fmt)
      FMT_U:   v = {w[31:12], 12'b0};
      FMT_J:   v = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      FMT_I:   v = {{20{w[31]}}, w[31:20]};
      FMT_S:   v = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   v = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      default: v = 32'd0;
    endcase
    // U-type is sign-extended as well, so bit 31 fills the upper half at XLEN=64
    return XLEN'($signed(v));
  endfunction

`ifdef IMM_GEN_ILLEGAL_EN
  function automatic logic illegal_of(input logic [6:0] w);
    return (w[1:0] != 2'b11) ||
           !(w[6:2] inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100,
                            5'b01000, 5'b11000, 5'b01100, 5'b00011, 5'b11100});
  endfunction
`endif

  logic [2:0]    in_fmt_s;
  logic [DW-1:0] in_data_s;
  logic          accept_s;
  logic          pop_s;
  logic          out_v_r;
  logic          skid_v_r;
  logic [DW-1:0] out_data_r;
  logic [DW-1:0] skid_data_r;

  assign in_fmt_s = fmt_of(in_insr_i[6:2]);
`ifdef IMM_GEN_ILLEGAL_EN
  assign in_data_s = {illegal_of(in_insr_i[6:0]), imm_of(in_insr_i[31:7], in_fmt_s), in_fmt_s, in_tag_i};
  assign {out_illegal_o, out_imm_o, out_fmt_o, out_tag_o} = out_data_r;
`else
  logic unused_s;
  assign unused_s  = &{1'b0, in_insr_i[1:0]};
  assign in_data_s = {imm_of(in_insr_i[31:7], in_fmt_s), in_fmt_s, in_tag_i};
  assign {out_imm_o, out_fmt_o, out_tag_o} = out_data_r;
`endif

  assign in_ready_o  = ~skid_v_r;
  assign out_valid_o = out_v_r;
  assign accept_s    = in_valid_i & ~skid_v_r;
  assign pop_s       = out_v_r & out_ready_i;

  // Output register refills from skid first (order), else from the input; skid catches an accept that cannot drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_v_r     <= 1'b0;
      skid_v_r    <= 1'b0;
      out_data_r  <= '0;
      skid_data_r <= '0;
    end else if (flush_i) begin
      out_v_r  <= 1'b0;
      skid_v_r <= 1'b0;
    end else begin
      if (!out_v_r || pop_s) begin
        if (skid_v_r) begin
          out_data_r <= skid_data_r;
          out_v_r    <= 1'b1;
        end else if (accept_s) begin
          out_data_r <= in_data_s;
          out_v_r    <= 1'b1;
        end else begin
          out_v_r <= 1'b0;
        end
      end
      if (skid_v_r) begin
        if (pop_s) begin
          skid_v_r <= 1'b0;
        end
      end else if (accept_s && out_v_r && !pop_s) begin
        skid_data_r <= in_data_s;
        skid_v_r    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe; drives an XLEN=32 and an XLEN=64 instance in lockstep
// against a queue-based reference model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] insr, tag;
  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [31:0] tag32, tag64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        ill32, ill64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .in_insr_i(insr), .in_tag_i(tag), .out_valid_o(ov32), .out_ready_i(out_ready),
    .out_imm_o(imm32), .out_fmt_o(fmt32), .out_tag_o(tag32)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal_o(ill32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .in_insr_i(insr), .in_tag_i(tag), .out_valid_o(ov64), .out_ready_i(out_ready),
    .out_imm_o(imm64), .out_fmt_o(fmt64), .out_tag_o(tag64)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal_o(ill64)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad   = 0;
  logic [4:0] ops [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100,
                           5'b01000, 5'b11000, 5'b01100, 5'b00011, 5'b11100};

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Immediates built by placing the field at the top of a signed int and arithmetic-shifting it down
  function automatic ent_t ref_model(input logic [31:0] w, input logic [31:0] t);
    ent_t e;
    int x;
    logic [4:0] op;
    op = w[6:2];
    e.tag = t;
    if (w[4:2] == 3'b101) begin
      e.fmt = 3'd4; x = {w[31:12], 12'b0};
    end else if (w[3:2] == 2'b11) begin
      e.fmt = 3'd5; x = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}; x = x >>> 11;
    end else if (w[4:2] == 3'b001 || {w[6:5], w[3:2]} == 4'b0000) begin
      e.fmt = 3'd1; x = w; x = x >>> 20;
    end else if (op == 5'b01000) begin
      e.fmt = 3'd2; x = {w[31:25], w[11:7], 20'b0}; x = x >>> 20;
    end else if (op == 5'b11000) begin
      e.fmt = 3'd3; x = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}; x = x >>> 19;
    end else begin
      e.fmt = 3'd0; x = 0;
    end
    e.imm = longint'(x);
    e.ill = (w[1:0] != 2'b11) || !(op inside {ops});
    return e;
  endfunction

  task automatic check_state();
    check_val("rdy32", rdy32, q.size() < 2);
    check_val("rdy64", rdy64, q.size() < 2);
    check_val("ov32", ov32, q.size() > 0);
    check_val("ov64", ov64, q.size() > 0);
    if (q.size() > 0) begin
      check_val("imm32", imm32, q[0].imm[31:0]);
      check_val("imm64", imm64, q[0].imm);
      check_val("fmt32", fmt32, q[0].fmt);
      check_val("fmt64", fmt64, q[0].fmt);
      check_val("tag32", tag32, q[0].tag);
      check_val("tag64", tag64, q[0].tag);
`ifdef IMM_GEN_ILLEGAL_EN
      check_val("ill32", ill32, q[0].ill);
      check_val("ill64", ill64, q[0].ill);
`endif
    end
  endtask

  // Called at a falling edge: drive, let the rising edge happen, update the model, check at the next falling edge
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] t,
                       input logic ordy, input logic fl);
    logic acc, pop;
    in_valid  = v;
    insr      = w;
    tag       = t;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_model(w, t));
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_ov32"}, ov32, 1'b0);
    check_val({name, "_ov64"}, ov64, 1'b0);
    check_val({name, "_rdy32"}, rdy32, 1'b1);
    check_val({name, "_imm32"}, imm32, 32'd0);
    check_val({name, "_imm64"}, imm64, 64'd0);
    check_val({name, "_fmt32"}, fmt32, 3'd0);
    check_val({name, "_tag32"}, tag32, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; insr = 32'd0; tag = 32'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,-1
    cycle(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    check_val("addi_ov", ov32, 1'b1);
    check_val("addi_imm", imm32, 32'hFFFFFFFF);
    check_val("addi_fmt", fmt32, 3'd1);

    // lui with bit 31 set, beq -4, on the 64-bit instance
    cycle(1'b1, 32'h80000037, 32'h101, 1'b1, 1'b0);
    check_val("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    check_val("lui_fmt64", fmt64, 3'd4);
    cycle(1'b1, 32'hFE000EE3, 32'h102, 1'b1, 1'b0);
    check_val("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    check_val("beq_fmt64", fmt64, 3'd3);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Backpressure: three back-to-back inputs, third held until space frees
    cycle(1'b1, 32'h00A00093, 32'd10, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B00093, 32'd11, 1'b0, 1'b0);
    check_val("bp_ready_low", rdy32, 1'b0);
    cycle(1'b1, 32'h00C00093, 32'd12, 1'b0, 1'b0);
    check_val("bp_held_ready", rdy32, 1'b0);
    check_val("bp_head_tag", tag32, 32'd10);
    cycle(1'b1, 32'h00C00093, 32'd12, 1'b1, 1'b0);
    check_val("bp_second_tag", tag32, 32'd11);
    cycle(1'b1, 32'h00C00093, 32'd12, 1'b1, 1'b0);
    check_val("bp_third_tag", tag32, 32'd12);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_val("bp_drained", ov32, 1'b0);

    // Flush at full occupancy with a valid input present
    cycle(1'b1, 32'h01400093, 32'd20, 1'b0, 1'b0);
    cycle(1'b1, 32'h01500093, 32'd21, 1'b0, 1'b0);
    cycle(1'b1, 32'h01600093, 32'd22, 1'b0, 1'b1);
    check_val("flush_ov", ov32, 1'b0);
    check_val("flush_rdy", rdy32, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_val("flush_gone", ov32, 1'b0);

    // Asynchronous reset between edges with one entry held
    cycle(1'b1, 32'h12345037, 32'd30, 1'b0, 1'b0);
    check_val("pre_rst_ov", ov32, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h02A00093, 32'd31, 1'b1, 1'b0);
    check_val("post_rst_tag", tag32, 32'd31);

`ifdef IMM_GEN_ILLEGAL_EN
    cycle(1'b1, 32'h00000000, 32'd40, 1'b1, 1'b0);
    check_val("ill_zero", ill32, 1'b1);
    cycle(1'b1, 32'h00000033, 32'd41, 1'b1, 1'b0);
    check_val("ill_add", ill32, 1'b0);
    check_val("add_imm", imm32, 32'd0);
    check_val("add_fmt", fmt32, 3'd0);
`endif

    // Random traffic with toggling backpressure and occasional flushes
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
      cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, output immediate width; legal values 32 or 64.
REQ-002 SHALL provide parameter TAG_W, default 32, width of the sideband tag carried alongside each instruction (e.g. PC).
REQ-003 SHALL provide port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port flush_i  input  1  synchronous discard of all held entries.
REQ-006 SHALL provide port in_valid_i  input  1  upstream instruction valid.
REQ-007 SHALL provide port in_ready_o  output  1  block can accept this cycle.
REQ-008 SHALL provide port in_insr_i  input  32  raw RV32 instruction word.
REQ-009 SHALL provide port in_tag_i  input  TAG_W  sideband tag.
REQ-010 SHALL provide port out_valid_o  output  1  output entry valid.
REQ-011 SHALL provide port out_ready_i  input  1  downstream accepts this cycle.
REQ-012 SHALL provide port out_imm_o  output  XLEN  sign-extended immediate.
REQ-013 SHALL provide port out_fmt_o  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-014 SHALL provide port out_tag_o  output  TAG_W  tag of the output entry.

Function
REQ-015 SHALL classify by first match, op = insr[6:2]: U if insr[4:2]=101; J if insr[3:2]=11; I if insr[4:2]=001 or {insr[6:5],insr[3:2]}=0000; S if op=01000; B if op=11000; else R.
REQ-016 SHALL form immediates: U {insr[31:12],12'b0}; J {insr[31],insr[19:12],insr[20],insr[30:21],0}; I insr[31:20]; S {insr[31:25],insr[11:7]}; B {insr[31],insr[7],insr[30:25],insr[11:8],0}; R zero.
REQ-017 SHALL sign-extend every non-R immediate from its top bit to XLEN bits, U-type included (bit 31 replicated for XLEN=64).
REQ-018 SHALL decode at input and register immediate, format and tag together; transfer latency exactly 1 cycle from accept to out_valid_o.
REQ-019 SHALL hold two entries (output register plus skid register); occupancy 0..2.
REQ-020 SHALL drive in_ready_o from registered state only: high iff skid register empty.
REQ-021 SHALL accept on in_valid_i & in_ready_o; pop on out_valid_o & out_ready_i; accept and pop in the same cycle SHALL be allowed at any occupancy where in_ready_o is high.
REQ-022 SHALL keep out_imm_o, out_fmt_o, out_tag_o stable while out_valid_o high and out_ready_i low.
REQ-023 SHALL preserve order; on pop with skid full, skid entry moves to output register in the same edge.
REQ-024 SHALL, when flush_i high, empty both entries and drop any same-cycle accept; flush has priority over accept and pop.
REQ-025 SHALL never drop or duplicate an entry when out_ready_i toggles arbitrarily.

Reset
REQ-026 SHALL, while rst_i high, force out_valid_o 0, in_ready_o 1, out_imm_o 0, out_fmt_o 0, out_tag_o 0, both entries empty, regardless of clock.
REQ-027 SHALL discard in-flight entries on reset mid-operation; first accept allowed on the first rising edge after rst_i falls.

Configuration
REQ-028 SHALL, with macro IMM_GEN_ILLEGAL_EN defined, add port out_illegal_o  output  1, registered with the entry, high when insr[1:0]!=11 or op not in {01101,00101,11011,11001,00000,00100,01000,11000,01100,00011,11100}; reset value 0.
REQ-029 SHALL, without IMM_GEN_ILLEGAL_EN, omit out_illegal_o and treat unknown opcodes per REQ-015/016 only.

Verification
REQ-030 SHALL cover: XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> out_imm_o 0xFFFFFFFF, out_fmt_o 1, one cycle later.
REQ-031 SHALL cover: XLEN=64, 0x80000037 (lui) -> out_imm_o 0xFFFFFFFF80000000, out_fmt_o 4; 0xFE000EE3 (beq -4) -> 0xFFFFFFFFFFFFFFFC, fmt 3.
REQ-032 SHALL cover: out_ready_i low, three back-to-back valid inputs -> in_ready_o low after two accepts, third held; out_ready_i high -> all three out in order, tags intact.
REQ-033 SHALL cover: occupancy 2, flush_i with in_valid_i high -> next cycle out_valid_o 0, in_ready_o 1, flushed input never appears.
REQ-034 SHALL cover: rst_i asserted between clock edges with occupancy 1 -> out_valid_o 0 immediately, all outputs 0.
REQ-035 SHALL cover with IMM_GEN_ILLEGAL_EN: 0x00000000 -> out_illegal_o 1; 0x00000033 (add) -> out_illegal_o 0, out_imm_o 0, fmt 0.
